pe_dot_sequencer: RTL

- Sequences one PE's dot-product datapath across a long reduction.
- A job is N chunks of DOT_SIZE elements. The block issues N filter-cache/feature reads, one per chunk, and tracks each chunk through the fixed-latency dot pipeline.
- It drives first/last/valid tags to the downstream accumulator, then signals job completion.
- It sits between the PE control plane and the dot datapath plus accumulator.

---
 rtl/pe_types.sv | 28 ++
 rtl/pe_tag_delay.sv | 36 +++
 rtl/pe_dot_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pe_types.sv
// Shared types and derived constants for the PE dot-product sequencer.
package pe_types;

    // Static PE pipeline configuration.
    typedef struct packed {
        int unsigned rd_latency;
        int unsigned dot_latency;
    } pe_cfg_t;

    localparam pe_cfg_t PE_CFG = '{rd_latency: 2, dot_latency: 5};

    // Cycles from a read strobe to its dot result at the accumulator input.
    localparam int unsigned PE_DOT_SEQ_TAG_DEPTH = PE_CFG.rd_latency + PE_CFG.dot_latency;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pe_dot_seq_state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } pe_dot_tag_t;

endpackage

// File: rtl/pe_tag_delay.sv
// Fixed-depth tag delay line that mirrors the read + dot pipeline, with an
// in-flight valid count so the sequencer can tell when it has drained.
module pe_tag_delay
    import pe_types::*;
#(
    parameter int unsigned DEPTH = PE_DOT_SEQ_TAG_DEPTH,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  pe_dot_tag_t   tag_in,
    output pe_dot_tag_t   tag_out,
    output logic [CW-1:0] in_flight
);

    pe_dot_tag_t stage [DEPTH];

    // Shift every cycle; the datapath it tracks has no enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= '0;
            end
            in_flight <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
            in_flight <= in_flight + CW'(tag_in.valid) - CW'(stage[DEPTH-1].valid);
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/pe_dot_sequencer.sv
// Sequences one PE's dot-product datapath across an N-chunk reduction:
// issues reads, tags each chunk through the fixed-latency pipeline, and
// pulses o_done once the last tagged result has reached the accumulator.
// Optional macro PE_DOT_SEQ_PERF_EN adds busy/stall performance counters.
module pe_dot_sequencer
    import pe_types::*;
#(
    parameter int unsigned RD_LATENCY  = PE_CFG.rd_latency,
    parameter int unsigned DOT_LATENCY = PE_CFG.dot_latency,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned CNT_WIDTH   = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [CNT_WIDTH-1:0]  i_num_chunks,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic                  i_stall,
    output logic                  o_ready,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic                  o_acc_valid,
    output logic                  o_acc_first,
    output logic                  o_acc_last,
    output logic                  o_done
`ifdef PE_DOT_SEQ_PERF_EN
    ,
    output logic [31:0]           o_perf_busy_cycles,
    output logic [31:0]           o_perf_stall_cycles
`endif
);

    localparam int unsigned TAG_DEPTH = RD_LATENCY + DOT_LATENCY;
    localparam int unsigned FLIGHT_W  = $clog2(TAG_DEPTH + 1);

    pe_dot_seq_state_t     state, state_next;
    logic [CNT_WIDTH-1:0]  num_chunks;
    logic [CNT_WIDTH-1:0]  issued;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  accept_c;
    logic                  issue_c;
    logic                  final_chunk_c;
    pe_dot_tag_t           tag_in;
    pe_dot_tag_t           tag_out;
    logic [FLIGHT_W-1:0]   in_flight;

    assign accept_c      = (state == ST_IDLE) && i_start;
    assign issue_c       = (state == ST_ISSUE) && !i_stall;
    assign final_chunk_c = (issued == num_chunks - CNT_WIDTH'(1));

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Job context: latched on accept, issue counter advances per read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            num_chunks <= '0;
            base_addr  <= '0;
            issued     <= '0;
        end else if (accept_c) begin
            num_chunks <= i_num_chunks;
            base_addr  <= i_base_addr;
            issued     <= '0;
        end else if (issue_c) begin
            issued <= issued + CNT_WIDTH'(1);
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_rd_en    = 1'b0;
        o_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    state_next = (i_num_chunks == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_rd_en = !i_stall;
                if (!i_stall && final_chunk_c) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last tag is at the output and nothing is behind it.
                if (tag_out.valid && tag_out.last && in_flight == FLIGHT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Tag for the chunk being issued this cycle.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = issue_c;
        tag_in.first = issue_c && (issued == '0);
        tag_in.last  = issue_c && final_chunk_c;
    end

    assign o_rd_addr = base_addr + ADDR_WIDTH'(issued);

    pe_tag_delay #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_delay (
        .clock     (clock),
        .reset     (reset),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .in_flight (in_flight)
    );

    assign o_acc_valid = tag_out.valid;
    assign o_acc_first = tag_out.first;
    assign o_acc_last  = tag_out.last;

`ifdef PE_DOT_SEQ_PERF_EN
    // Saturating busy/stall counters, restarted by each accepted job.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_perf_busy_cycles  <= '0;
            o_perf_stall_cycles <= '0;
        end else if (accept_c) begin
            o_perf_busy_cycles  <= '0;
            o_perf_stall_cycles <= '0;
        end else begin
            if (state != ST_IDLE && o_perf_busy_cycles != '1) begin
                o_perf_busy_cycles <= o_perf_busy_cycles + 32'd1;
            end
            if (state == ST_ISSUE && i_stall && o_perf_stall_cycles != '1) begin
                o_perf_stall_cycles <= o_perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
